// File: rtl/axil_uart_pkg.sv
// axil_uart_pkg: shared definitions for the AXI-Lite UART register front end.
// Holds register word offsets (addr[3:2]), STATUS bit positions, the AXI
// response encoding and the write/read channel FSM state types.
package axil_uart_pkg;

  localparam logic [1:0] TXDATA   = 2'd0;
  localparam logic [1:0] RXDATA   = 2'd1;
  localparam logic [1:0] STATUS   = 2'd2;
  localparam logic [1:0] BAUD_DIV = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_DROP  = 4;

  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

endpackage

// File: rtl/axil_uart_regs_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports: clk, rst (async high); push/din write side; pop/dout read side
// (dout is the head entry, valid while !empty); full/empty flags.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/axil_uart_regs.sv
// axil_uart_regs: AXI4-Lite slave register block for the UART bridge.
// Ports: clk, rst (async high); s_axi_* AXI-Lite slave (AW/W/B, AR/R);
// tx_data/tx_valid/tx_ready byte stream out of a TX FIFO; rx_data/rx_valid
// single-cycle received byte; baud_div divisor shared by the UART stages.
// Map (addr[3:2]): 0 TXDATA (push), 1 RXDATA (pop), 2 STATUS (read-clear
// of overrun/drop), 3 BAUD_DIV. Anything with addr above bit 3 is SLVERR.
module axil_uart_regs
  import axil_uart_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          TX_DEPTH = 4,
  parameter logic [15:0] BAUD_RST = 16'd868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [15:0]       baud_div
);

  // ---------------- write channel ----------------
  wstate_t           wstate, wstate_n;
  logic              aw_held, w_held, aw_hs, w_hs, wr_fire;
  logic [ADDR_W-1:0] awaddr_q, wa;
  logic [15:0]       wdata_q, wd;
  logic [1:0]        wstrb_q, ws;
  resp_t             bresp_q;
  logic              wr_map;
  logic [1:0]        wr_off;

  // Readies are gated by rst so they are low throughout reset.
  assign s_axi_awready = !rst && (wstate == W_IDLE) && !aw_held;
  assign s_axi_wready  = !rst && (wstate == W_IDLE) && !w_held;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // Effective beat: the held copy if captured earlier, else the live bus.
  assign wa = aw_held ? awaddr_q : s_axi_awaddr;
  assign wd = w_held  ? wdata_q  : s_axi_wdata[15:0];
  assign ws = w_held  ? wstrb_q  : s_axi_wstrb[1:0];
  assign wr_map = (wa[ADDR_W-1:4] == '0);
  assign wr_off = wa[3:2];

  always_comb begin
    wstate_n = wstate;
    wr_fire  = 1'b0;
    case (wstate)
      W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) begin
        wr_fire  = 1'b1;
        wstate_n = W_RESP;
      end
      W_RESP: if (s_axi_bready) wstate_n = W_IDLE;
      default: wstate_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate   <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      wstate <= wstate_n;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata[15:0];
        wstrb_q <= s_axi_wstrb[1:0];
      end
      if (wr_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_map ? OKAY : SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end
  end

  assign s_axi_bvalid = (wstate == W_RESP);
  assign s_axi_bresp  = bresp_q;

  // ---------------- read channel ----------------
  rstate_t     rstate, rstate_n;
  logic        ar_hs, rd_map, rx_pop, st_clr;
  logic [1:0]  rd_off;
  logic [31:0] rd_val, rdata_q;
  resp_t       rresp_q;

  logic        tx_full, tx_empty, tx_pop, tx_push, tx_drop_set, baud_we;
  logic        rx_full, rx_ovr, tx_drop;
  logic [7:0]  rx_hold;
  logic [15:0] baud_q, baud_nv;

  assign s_axi_arready = !rst && (rstate == R_IDLE);
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign rd_map = (s_axi_araddr[ADDR_W-1:4] == '0);
  assign rd_off = s_axi_araddr[3:2];
  assign rx_pop = ar_hs && rd_map && (rd_off == RXDATA);
  assign st_clr = ar_hs && rd_map && (rd_off == STATUS);

  always_comb begin
    rd_val = '0;
    if (rd_map) begin
      case (rd_off)
        RXDATA: rd_val = {23'b0, rx_full, rx_hold};
        STATUS: begin
          rd_val[ST_TX_FULL]  = tx_full;
          rd_val[ST_TX_EMPTY] = tx_empty;
          rd_val[ST_RX_FULL]  = rx_full;
          rd_val[ST_RX_OVR]   = rx_ovr;
          rd_val[ST_TX_DROP]  = tx_drop;
        end
        BAUD_DIV: rd_val = {16'b0, baud_q};
        default:  rd_val = '0;
      endcase
    end
  end

  always_comb begin
    rstate_n = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_n = R_RESP;
      R_RESP:  if (s_axi_rready) rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate  <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      rstate <= rstate_n;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_map ? OKAY : SLVERR;
      end
    end
  end

  assign s_axi_rvalid = (rstate == R_RESP);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

  // ---------------- TX FIFO ----------------
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push     = wr_fire && wr_map && (wr_off == TXDATA) && ws[0];
  assign tx_drop_set = tx_push && tx_full && !tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (wd[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_valid = !tx_empty;

  // ---------------- BAUD_DIV ----------------
  assign baud_we = wr_fire && wr_map && (wr_off == BAUD_DIV);

  always_comb begin
    baud_nv = baud_q;
    if (ws[0]) baud_nv[7:0]  = wd[7:0];
    if (ws[1]) baud_nv[15:8] = wd[15:8];
    if (baud_nv == '0) baud_nv = 16'd1;  // divide-by-zero is meaningless
  end

  // ---------------- RX hold and sticky status ----------------
  // Set events are applied after clears so a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= BAUD_RST;
      rx_hold <= '0;
      rx_full <= 1'b0;
      rx_ovr  <= 1'b0;
      tx_drop <= 1'b0;
    end else begin
      if (baud_we) baud_q <= baud_nv;
      if (st_clr) begin
        rx_ovr  <= 1'b0;
        tx_drop <= 1'b0;
      end
      if (tx_drop_set) tx_drop <= 1'b1;
      if (rx_valid) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
        if (rx_full && !rx_pop) rx_ovr <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign baud_div = baud_q;

  // Bus bits with no register behind them.
  logic unused_bits;
  assign unused_bits = ^{s_axi_wdata[31:16], s_axi_wstrb[3:2],
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axil_uart_regs.sv
// Bench for axil_uart_regs: directed AXI-Lite transactions, a transaction
// level model (queue for the TX FIFO, plain variables for registers) and a
// per-cycle compare of the TX stream and baud divisor against that model.
module tb_axil_uart_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0;
  logic        s_axi_arvalid = 0, s_axi_rready = 0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 0;
  logic [15:0] baud_div;

  always #5 clk = ~clk;

  axil_uart_regs dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .baud_div(baud_div)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  mq[$];
  logic [15:0] m_baud = 16'd868;
  logic [7:0]  m_hold = '0;
  bit          m_full = 0, m_ovr = 0, m_drop = 0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_rresp = '0, exp_bresp = '0;
  // Transaction events: set by tasks at a negedge for the following posedge.
  bit          ev_wr = 0, ev_rd = 0;
  logic [31:0] ev_waddr = '0, ev_wdata = '0, ev_raddr = '0;
  logic [3:0]  ev_wstrb = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_baud = 16'd868; m_hold = '0;
      m_full = 0; m_ovr = 0; m_drop = 0;
    end else begin
      bit popq, rpop, sclr, map;
      logic [1:0]  off;
      logic [15:0] nb;
      popq = tx_ready && (mq.size() > 0);
      rpop = 0; sclr = 0;
      if (ev_rd) begin
        map = (ev_raddr[31:4] == 0); off = ev_raddr[3:2];
        exp_rresp = map ? 2'b00 : 2'b10;
        exp_rdata = 0;
        if (map) begin
          if (off == 2'd1) begin exp_rdata = {23'b0, m_full, m_hold}; rpop = 1; end
          if (off == 2'd2) begin
            exp_rdata = {27'b0, m_drop, m_ovr, m_full, mq.size() == 0, mq.size() == 4};
            sclr = 1;
          end
          if (off == 2'd3) exp_rdata = {16'b0, m_baud};
        end
      end
      if (sclr) begin m_ovr = 0; m_drop = 0; end
      if (rx_valid) begin
        if (m_full && !rpop) m_ovr = 1;
        m_hold = rx_data; m_full = 1;
      end else if (rpop) m_full = 0;
      if (ev_wr) begin
        map = (ev_waddr[31:4] == 0); off = ev_waddr[3:2];
        exp_bresp = map ? 2'b00 : 2'b10;
        if (map && off == 2'd0 && ev_wstrb[0]) begin
          if (mq.size() < 4 || popq) mq.push_back(ev_wdata[7:0]);
          else m_drop = 1;
        end
        if (map && off == 2'd3) begin
          nb = m_baud;
          if (ev_wstrb[0]) nb[7:0]  = ev_wdata[7:0];
          if (ev_wstrb[1]) nb[15:8] = ev_wdata[15:8];
          if (nb == 0) nb = 16'd1;
          m_baud = nb;
        end
      end
      if (popq) void'(mq.pop_front());
    end
  end

  // Per-cycle compare of the TX stream and divisor.
  always @(negedge clk) begin
    if (!rst) begin
      chk("tx_valid", tx_valid, mq.size() != 0);
      if (mq.size() != 0) chk("tx_data", tx_data, mq[0]);
      chk("baud_div", baud_div, m_baud);
    end
  end

  // ---------------- transaction tasks (called at a negedge) ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit hold_b,
                           output logic [1:0] resp);
    bit awd = 0, wd = 0, aw_hs, w_hs, done = 0;
    int t = 0;
    s_axi_bready = !hold_b;
    while (!done && t < 50) begin
      s_axi_awvalid = !awd && (t >= aw_dly); s_axi_awaddr = a;
      s_axi_wvalid  = !wd && (t >= w_dly);   s_axi_wdata = d; s_axi_wstrb = s;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      if ((awd || aw_hs) && (wd || w_hs)) begin
        ev_wr = 1; ev_waddr = a; ev_wdata = d; ev_wstrb = s; done = 1;
      end
      @(posedge clk);
      awd |= aw_hs; wd |= w_hs;
      @(negedge clk);
      ev_wr = 0; s_axi_awvalid = 0; s_axi_wvalid = 0;
      if (!done) chk("bvalid_early", s_axi_bvalid, 0);
      t++;
    end
    chk("write_handshake", done, 1);
    chk("bvalid", s_axi_bvalid, 1);
    chk("bresp", s_axi_bresp, exp_bresp);
    chk("awready_busy", s_axi_awready, 0);
    resp = s_axi_bresp;
    if (!hold_b) begin
      @(posedge clk); @(negedge clk);
      chk("bvalid_clear", s_axi_bvalid, 0);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input bit rx_en, input logic [7:0] rx_b,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done = 0;
    int t = 0;
    s_axi_rready = 1;
    while (!done && t < 20) begin
      s_axi_arvalid = 1; s_axi_araddr = a;
      if (s_axi_arready) begin
        done = 1; ev_rd = 1; ev_raddr = a;
        if (rx_en) begin rx_valid = 1; rx_data = rx_b; end
      end
      @(posedge clk); @(negedge clk);
      ev_rd = 0; s_axi_arvalid = 0; rx_valid = 0;
      t++;
    end
    chk("read_handshake", done, 1);
    chk("rvalid", s_axi_rvalid, 1);
    chk("rdata", s_axi_rdata, exp_rdata);
    chk("rresp", s_axi_rresp, exp_rresp);
    chk("arready_busy", s_axi_arready, 0);
    data = s_axi_rdata; resp = s_axi_rresp;
    @(posedge clk); @(negedge clk);
    chk("rvalid_clear", s_axi_rvalid, 0);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1; rx_data = b;
    @(posedge clk); @(negedge clk);
    rx_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_baud", baud_div, 16'd868);
    rst = 0;
    #1;
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_wready", s_axi_wready, 1);
    chk("post_rst_arready", s_axi_arready, 1);
    @(negedge clk);

    // Reset register values
    axi_read(32'hC, 0, 8'h0, d, r);
    chk("lit_baud_rst", d, 32'h0000_0364);
    chk("lit_baud_resp", r, 2'b00);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_status_rst", d, 32'h0000_0002);

    // AW three cycles before W
    axi_write(32'h0, 32'h41, 4'h1, 0, 3, 0, r);
    chk("lit_tx_valid", tx_valid, 1);
    chk("lit_tx_data", tx_data, 8'h41);
    repeat (3) @(negedge clk);
    chk("lit_tx_stable", tx_data, 8'h41);
    tx_ready = 1; @(negedge clk); tx_ready = 0;
    chk("lit_tx_drained", tx_valid, 0);

    // Overfill: fifth byte dropped
    for (int i = 0; i < 5; i++) axi_write(32'h0, 32'h10 + i, 4'h1, 0, 0, 0, r);
    chk("lit_fifo_head", tx_data, 8'h10);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_status_full_drop", d, 32'h0000_0011);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_status_drop_clr", d, 32'h0000_0001);

    // Push coinciding with pop on a full FIFO is accepted
    tx_ready = 1;
    axi_write(32'h0, 32'h24, 4'h1, 0, 0, 0, r);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_no_drop", d[4], 0);
    repeat (6) @(negedge clk);
    tx_ready = 0;
    chk("lit_tx_empty", tx_valid, 0);

    // TXDATA write with wstrb[0] clear pushes nothing
    axi_write(32'h0, 32'h66, 4'hE, 0, 1, 0, r);
    chk("lit_nostrb", tx_valid, 0);

    // RX overrun
    rx_pulse(8'h5A);
    rx_pulse(8'hA5);
    axi_read(32'h4, 0, 8'h0, d, r);
    chk("lit_rxdata", d, 32'h0000_01A5);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_status_ovr", d, 32'h0000_000A);

    // Pop coinciding with a new byte
    rx_pulse(8'h77);
    axi_read(32'h4, 1, 8'h33, d, r);
    chk("lit_rx_pop_same", d, 32'h0000_0177);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_status_no_ovr", d, 32'h0000_0006);
    axi_read(32'h4, 0, 8'h0, d, r);
    chk("lit_rx_new", d, 32'h0000_0133);

    // Unmapped access and read-as-zero TXDATA
    axi_write(32'h10, 32'h55, 4'hF, 1, 0, 0, r);
    chk("lit_wr_slverr", r, 2'b10);
    axi_read(32'h10, 0, 8'h0, d, r);
    chk("lit_rd_slverr", r, 2'b10);
    chk("lit_rd_unmapped", d, 0);
    axi_read(32'h0, 0, 8'h0, d, r);
    chk("lit_txdata_rd", d, 0);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_status_unchanged", d, 32'h0000_0002);
    axi_write(32'h8, 32'h1F, 4'hF, 0, 0, 0, r);
    chk("lit_status_wr_okay", r, 2'b00);

    // BAUD_DIV zero clamp and byte lanes
    axi_write(32'hC, 32'h0, 4'h3, 0, 0, 0, r);
    axi_read(32'hC, 0, 8'h0, d, r);
    chk("lit_baud_one", d, 32'h0000_0001);
    axi_write(32'hC, 32'h1234, 4'h1, 0, 0, 0, r);
    axi_read(32'hC, 0, 8'h0, d, r);
    chk("lit_baud_lane", d, 32'h0000_0034);
    axi_write(32'hC, 32'h0100, 4'h3, 0, 0, 0, r);

    // Reset while B response waits
    axi_write(32'h0, 32'h99, 4'h1, 0, 0, 1, r);
    chk("lit_pre_rst_tx", tx_valid, 1);
    rst = 1;
    #1;
    chk("lit_rst_bvalid", s_axi_bvalid, 0);
    chk("lit_rst_tx_valid", tx_valid, 0);
    chk("lit_rst_baud", baud_div, 16'd868);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("lit_post_bvalid", s_axi_bvalid, 0);
    axi_read(32'h8, 0, 8'h0, d, r);
    chk("lit_post_status", d, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
